rgb_frame_sink: RTL and testbench
=================================

// Module: rgb_frame_sink
// PURPOSE
//  Consumer end of the raster RGB pixel stream driven by the image-load bench/front end: one R,G,B triple per clk.
//  Classifies each pixel as skin/non-skin and stores a 1-bit mask per pixel.
//  Accumulates mask-pixel coordinates and computes the integer centroid with a serial divider.
//  On process_en it streams the mask back out in raster order as 8-bit values, framed by mask_valid.
// PARAMETERS
//  IMG_WIDTH     256  pixels per line (power of 2, <=256)
//  IMG_HEIGHT    256  lines per frame (power of 2, <=256)
//  DEPTH         8    bits per colour channel
//  SKIN_R_MIN    95   R must be strictly greater than this
//  SKIN_RG_DIFF  15   (R-G) must be strictly greater than this
// PORTS
//  clk             in   1      system clock, rising edge
//  rst_n           in   1      asynchronous reset, active low
//  pix_r           in   DEPTH  red sample
//  pix_g           in   DEPTH  green sample
//  pix_b           in   DEPTH  blue sample
//  load_en         in   1      pixel on pix_* is valid this cycle
//  process_en      in   1      request mask readout (level, sampled)
//  mask_out        out  DEPTH  8'hFF skin / 8'h00 non-skin (all-ones/zeros for DEPTH)
//  mask_valid      out  1      mask_out valid; high for exactly N=W*H consecutive cycles
//  centroid_x      out  8      mean x of skin pixels
//  centroid_y      out  8      mean y of skin pixels
//  centroid_ready  out  1      centroid_x/y valid; sticky
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; mask_out=0, mask_valid=0, centroid_x/y=0, centroid_ready=0;
//   pixel counter, x/y counters, sum_x, sum_y, count cleared. Mask RAM contents are don't-care.
//  Reset mid-operation aborts immediately; no partial stream continues after release.
//  FSM: IDLE -> LOAD -> DIVIDE -> READY -> STREAM -> DONE.
//  IDLE/DONE: load_en=1 captures pixel 0 on that edge, clears sums, drops centroid_ready -> LOAD.
//   load_en has priority over process_en.
//  LOAD: each edge with load_en=1 consumes one pixel at (x,y); x wraps at IMG_WIDTH-1 and increments y.
//   load_en=0 stalls without consuming. process_en is ignored.
//  Skin rule: R>SKIN_R_MIN && R>G && R>B && (R-G)>SKIN_RG_DIFF.
//   Compare unsigned; R-G is evaluated only when R>G.
//  On skin: mask[idx]=1, sum_x+=x, sum_y+=y, count+=1. Sum width = 8+log2(N); count width = log2(N)+1. No overflow.
//  Consuming pixel N-1 -> DIVIDE on the next edge.
//  DIVIDE: two parallel restoring dividers compute sum_x/count and sum_y/count (truncating).
//   One quotient bit per cycle; fixed 8 cycles, because the quotient is <256.
//   count==0: centroid=(0,0), no division.
//   On exit, centroid_x/y are registered, centroid_ready=1 (held until next load or reset) -> READY.
//  READY: process_en sampled high at edge k -> STREAM. RAM read is 1-cycle latency.
//   mask_valid=1 from edge k+2 through edge k+1+N, with mask_out = mask[0..N-1] in order.
//   Afterwards mask_valid=0, mask_out=0 -> DONE.
//  STREAM cannot be paused; process_en/load_en are ignored during STREAM.
//  process_en before READY (IDLE/LOAD/DIVIDE) is ignored, not queued. process_en held high across READY starts a stream.
//  DONE: outputs held low and centroid held. A new frame restarts via load_en.
// TESTING
//  1 All-black frame (0,0,0): centroid_ready 8 cycles after last pixel, centroid=(0,0); N cycles of mask_out=00, then mask_valid falls.
//  2 Single skin pixel (200,100,80) at (x=37,y=90), rest black: centroid=(37,90); mask_out=FF only at stream beat 90*W+37.
//  3 Skin block x 100..109, y 50..59: centroid=(104,54); exactly 100 FF beats.
//  4 Threshold edges: (95,50,50), (150,135,100), (150,150,10) -> all 00; (96,50,50) -> FF.
//  5 load_en toggled 1/0 every cycle: still exactly N pixels consumed; process_en pulsed during LOAD -> no mask_valid.
//  6 rst_n low mid-STREAM: outputs zero on the same edge; full reload -> identical mask and centroid.

Source files
------------

// File: rtl/rgb_frame_sink.sv
// Skin-mask frame sink: classifies a raster RGB stream, stores a 1-bit mask per pixel,
// computes the skin centroid with a serial divider and streams the mask back on request.
module rgb_frame_sink #(
    parameter int IMG_WIDTH    = 256,
    parameter int IMG_HEIGHT   = 256,
    parameter int DEPTH        = 8,
    parameter int SKIN_R_MIN   = 95,
    parameter int SKIN_RG_DIFF = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] pix_r,
    input  logic [DEPTH-1:0] pix_g,
    input  logic [DEPTH-1:0] pix_b,
    input  logic             load_en,
    input  logic             process_en,
    output logic [DEPTH-1:0] mask_out,
    output logic             mask_valid,
    output logic [7:0]       centroid_x,
    output logic [7:0]       centroid_y,
    output logic             centroid_ready
);
    localparam int N    = IMG_WIDTH * IMG_HEIGHT;
    localparam int XW   = $clog2(IMG_WIDTH);
    localparam int IDXW = $clog2(N);
    localparam int SW   = 8 + IDXW;
    localparam int CW   = IDXW + 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(N - 1);
    localparam logic [DEPTH-1:0] R_MIN    = DEPTH'(SKIN_R_MIN);
    localparam logic [DEPTH-1:0] RG_DIFF  = DEPTH'(SKIN_RG_DIFF);

    typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, READY, STREAM, DONE} state_t;

    state_t          state;
    logic            mem [N];
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] rd_idx;
    logic [SW-1:0]   sum_x, sum_y;
    logic [SW-1:0]   rem_x, rem_y, dvs;
    logic [CW-1:0]   count;
    logic [7:0]      q_x, q_y;
    logic [2:0]      div_cnt;
    logic            issuing, rd_pend, rd_bit;

    logic            first, consume, skin, ge_x, ge_y;
    logic [7:0]      cur_x, cur_y;
    logic [DEPTH-1:0] rg_diff;
    logic [SW-1:0]   sum_x_next, sum_y_next;
    logic [CW-1:0]   count_next;

    // The pixel index is {y,x}, so coordinates fall straight out of the index bits.
    always_comb begin
        first      = (state == IDLE) || (state == DONE);
        consume    = load_en && (first || (state == LOAD));
        cur_x      = 8'(idx[XW-1:0]);
        cur_y      = 8'(idx >> XW);
        rg_diff    = pix_r - pix_g;
        skin       = (pix_r > R_MIN) && (pix_r > pix_g) && (pix_r > pix_b) && (rg_diff > RG_DIFF);
        sum_x_next = (first ? '0 : sum_x) + (skin ? {{(SW-8){1'b0}}, cur_x} : '0);
        sum_y_next = (first ? '0 : sum_y) + (skin ? {{(SW-8){1'b0}}, cur_y} : '0);
        count_next = (first ? '0 : count) + {{(CW-1){1'b0}}, skin};
        ge_x       = rem_x >= dvs;
        ge_y       = rem_y >= dvs;
    end

    always_ff @(posedge clk) begin
        if (consume)
            mem[idx] <= skin;
        rd_bit <= mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            rd_idx         <= '0;
            sum_x          <= '0;
            sum_y          <= '0;
            count          <= '0;
            rem_x          <= '0;
            rem_y          <= '0;
            dvs            <= '0;
            q_x            <= '0;
            q_y            <= '0;
            div_cnt        <= '0;
            issuing        <= 1'b0;
            rd_pend        <= 1'b0;
            mask_out       <= '0;
            mask_valid     <= 1'b0;
            centroid_x     <= '0;
            centroid_y     <= '0;
            centroid_ready <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, LOAD: begin
                    if (consume) begin
                        sum_x <= sum_x_next;
                        sum_y <= sum_y_next;
                        count <= count_next;
                        idx   <= idx + 1'b1;
                        if (first) begin
                            centroid_ready <= 1'b0;
                            state          <= LOAD;
                        end
                        // Divisor starts at count<<7 so eight shifts yield an 8-bit quotient.
                        if (idx == LAST_IDX) begin
                            rem_x   <= sum_x_next;
                            rem_y   <= sum_y_next;
                            dvs     <= {{(SW-CW){1'b0}}, count_next} << 7;
                            div_cnt <= '0;
                            state   <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (ge_x) rem_x <= rem_x - dvs;
                    if (ge_y) rem_y <= rem_y - dvs;
                    q_x     <= {q_x[6:0], ge_x};
                    q_y     <= {q_y[6:0], ge_y};
                    dvs     <= dvs >> 1;
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == 3'd7) begin
                        centroid_x     <= (count == '0) ? 8'd0 : {q_x[6:0], ge_x};
                        centroid_y     <= (count == '0) ? 8'd0 : {q_y[6:0], ge_y};
                        centroid_ready <= 1'b1;
                        state          <= READY;
                    end
                end
                READY: begin
                    if (process_en) begin
                        rd_idx  <= '0;
                        issuing <= 1'b1;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    // rd_pend tracks the one-cycle RAM latency in front of mask_out.
                    if (issuing) begin
                        rd_pend <= 1'b1;
                        rd_idx  <= rd_idx + 1'b1;
                        if (rd_idx == LAST_IDX)
                            issuing <= 1'b0;
                    end else begin
                        rd_pend <= 1'b0;
                    end
                    mask_valid <= rd_pend;
                    mask_out   <= (rd_pend && rd_bit) ? '1 : '0;
                    if (!issuing && !rd_pend)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_frame_sink.sv
// Directed bench for rgb_frame_sink on a reduced 32x8 frame so full frames stay short.
module tb_rgb_frame_sink;
    localparam int W = 32;
    localparam int H = 8;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pix_r, pix_g, pix_b;
    logic       load_en, process_en;
    logic [7:0] mask_out, centroid_x, centroid_y;
    logic       mask_valid, centroid_ready;

    int checks = 0;
    int passed = 0;
    int valid_seen = 0;

    logic [23:0] img [N];
    logic [7:0]  cap [N];

    rgb_frame_sink #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DEPTH(8), .SKIN_R_MIN(95), .SKIN_RG_DIFF(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .load_en(load_en), .process_en(process_en),
        .mask_out(mask_out), .mask_valid(mask_valid),
        .centroid_x(centroid_x), .centroid_y(centroid_y),
        .centroid_ready(centroid_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mask_valid) valid_seen++;

    function automatic bit exp_skin(input logic [23:0] p);
        int r, g, b;
        r = p[23:16]; g = p[15:8]; b = p[7:0];
        return (r > 95) && (r > g) && (r > b) && ((r - g) > 15);
    endfunction

    task automatic clear_img();
        for (int i = 0; i < N; i++) img[i] = 24'h0;
    endtask

    task automatic set_block();
        clear_img();
        for (int y = 2; y <= 5; y++)
            for (int x = 10; x <= 19; x++)
                img[y*W + x] = {8'd200, 8'd100, 8'd80};
    endtask

    task automatic load_image(input bit toggle, input bit pulse, output int lat, output logic rdy_first);
        rdy_first = 1'bx;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            process_en = 1'b0;
            load_en = 1'b1;
            {pix_r, pix_g, pix_b} = img[i];
            if (i == 1) rdy_first = centroid_ready;
            if (toggle && i < N-1) begin
                @(negedge clk);
                load_en = 1'b0;
                {pix_r, pix_g, pix_b} = 24'hFA0000;
                process_en = pulse && (i == 100);
            end
        end
        @(posedge clk);
        #1;
        load_en = 1'b0;
        process_en = 1'b0;
        {pix_r, pix_g, pix_b} = 24'h0;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (centroid_ready) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_stream(output int first, output int beats, output int ones,
                              output int bad, output bit contiguous);
        bit ended;
        first = -1; beats = 0; ones = 0; bad = 0; contiguous = 1'b1; ended = 1'b0;
        @(negedge clk); process_en = 1'b1;
        @(negedge clk); process_en = 1'b0;
        for (int c = 1; c <= N + 10; c++) begin
            @(posedge clk);
            #1;
            if (mask_valid) begin
                if (beats == 0) first = c;
                if (ended) contiguous = 1'b0;
                if (beats < N) cap[beats] = mask_out;
                beats++;
                if (mask_out == 8'hFF) ones++;
                else if (mask_out != 8'h00) bad++;
            end else begin
                if (beats > 0) ended = 1'b1;
                if (mask_out != 8'h00) bad++;
            end
        end
    endtask

    function automatic int model_errors();
        int errs = 0;
        for (int i = 0; i < N; i++)
            if (cap[i] !== (exp_skin(img[i]) ? 8'hFF : 8'h00)) errs++;
        return errs;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; load_en = 1'b0; process_en = 1'b0;
        {pix_r, pix_g, pix_b} = 24'h0;
        #23;
        checks++;
        if ({mask_out, mask_valid, centroid_x, centroid_y, centroid_ready} !== 26'h0)
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {mask_out, mask_valid, centroid_x, centroid_y, centroid_ready});
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        valid_seen = 0;
        @(negedge clk); process_en = 1'b1;
        @(negedge clk); process_en = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (valid_seen !== 0) $display("[TB] FAIL idle_process_ignored: valid beats %0d required 0", valid_seen);
        else passed++;
    endtask

    task automatic check_frame(input string name, input int lat, input int cx, input int cy,
                               input int exp_ones);
        int first, beats, ones, bad;
        bit contiguous;
        checks++;
        if (lat !== 8) $display("[TB] FAIL %s_ready_latency: got %0d required 8", name, lat);
        else passed++;
        checks++;
        if (centroid_x !== 8'(cx) || centroid_y !== 8'(cy))
            $display("[TB] FAIL %s_centroid: got (%0d,%0d) required (%0d,%0d)",
                     name, centroid_x, centroid_y, cx, cy);
        else passed++;
        run_stream(first, beats, ones, bad, contiguous);
        checks++;
        if (first !== 2 || beats !== N || !contiguous)
            $display("[TB] FAIL %s_stream_frame: first %0d beats %0d contiguous %0d required 2 %0d 1",
                     name, first, beats, contiguous, N);
        else passed++;
        checks++;
        if (ones !== exp_ones || bad !== 0)
            $display("[TB] FAIL %s_ff_count: got %0d (bad %0d) required %0d", name, ones, bad, exp_ones);
        else passed++;
        checks++;
        if (model_errors() !== 0)
            $display("[TB] FAIL %s_mask_order: %0d beats differ required 0", name, model_errors());
        else passed++;
        checks++;
        if (mask_valid !== 1'b0 || mask_out !== 8'h00 || centroid_ready !== 1'b1)
            $display("[TB] FAIL %s_done_state: valid %0d out %h ready %0d required 0 00 1",
                     name, mask_valid, mask_out, centroid_ready);
        else passed++;
    endtask

    task automatic test_black();
        int lat; logic rf;
        clear_img();
        load_image(1'b0, 1'b0, lat, rf);
        check_frame("black", lat, 0, 0, 0);
    endtask

    task automatic test_single();
        int lat; logic rf;
        clear_img();
        img[5*W + 21] = {8'd200, 8'd100, 8'd80};
        load_image(1'b0, 1'b0, lat, rf);
        checks++;
        if (rf !== 1'b0) $display("[TB] FAIL single_ready_drop: got %0d required 0", rf);
        else passed++;
        check_frame("single", lat, 21, 5, 1);
        checks++;
        if (cap[5*W + 21] !== 8'hFF) $display("[TB] FAIL single_beat: got %h required ff", cap[5*W + 21]);
        else passed++;
    endtask

    task automatic test_block();
        int lat; logic rf;
        set_block();
        load_image(1'b0, 1'b0, lat, rf);
        check_frame("block", lat, 14, 3, 40);
    endtask

    task automatic test_thresholds();
        int lat; logic rf;
        logic [7:0] exp_beats [8];
        int pos [8];
        clear_img();
        img[0]   = {8'd95,  8'd50,  8'd50};
        img[1]   = {8'd150, 8'd135, 8'd100};
        img[2]   = {8'd150, 8'd150, 8'd10};
        img[3]   = {8'd96,  8'd50,  8'd50};
        img[4]   = {8'd96,  8'd20,  8'd96};
        img[5]   = {8'd96,  8'd81,  8'd50};
        img[40]  = {8'd96,  8'd80,  8'd50};
        img[255] = {8'd200, 8'd10,  8'd10};
        pos = '{0, 1, 2, 3, 4, 5, 40, 255};
        exp_beats = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
        load_image(1'b0, 1'b0, lat, rf);
        check_frame("thresh", lat, 14, 2, 3);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[pos[i]] !== exp_beats[i])
                $display("[TB] FAIL thresh_pixel_%0d: got %h required %h", pos[i], cap[pos[i]], exp_beats[i]);
            else passed++;
        end
    endtask

    task automatic test_toggle();
        int lat; logic rf;
        set_block();
        valid_seen = 0;
        load_image(1'b1, 1'b1, lat, rf);
        repeat (3) @(negedge clk);
        checks++;
        if (valid_seen !== 0) $display("[TB] FAIL toggle_process_ignored: valid beats %0d required 0", valid_seen);
        else passed++;
        check_frame("toggle", lat, 14, 3, 40);
    endtask

    task automatic test_reset_midstream();
        int lat; logic rf;
        set_block();
        load_image(1'b0, 1'b0, lat, rf);
        @(negedge clk); process_en = 1'b1;
        @(negedge clk); process_en = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (mask_valid !== 1'b1) $display("[TB] FAIL midstream_active: valid %0d required 1", mask_valid);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mask_out, mask_valid, centroid_x, centroid_y, centroid_ready} !== 26'h0)
            $display("[TB] FAIL midstream_reset_zero: got %h required 0",
                     {mask_out, mask_valid, centroid_x, centroid_y, centroid_ready});
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        valid_seen = 0;
        repeat (20) @(negedge clk);
        checks++;
        if (valid_seen !== 0) $display("[TB] FAIL midstream_no_resume: valid beats %0d required 0", valid_seen);
        else passed++;
        load_image(1'b0, 1'b0, lat, rf);
        check_frame("reload", lat, 14, 3, 40);
    endtask

    initial begin
        test_reset();
        test_black();
        test_single();
        test_block();
        test_thresholds();
        test_toggle();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
